// File: rtl/timer_apb_pkg.sv
// Shared definitions for the timer APB front-end.
// Holds register offsets, the pending-clear bit position, the access FSM
// state type and a lowest-set-bit helper.
// Optional feature macro used by the top: TMR_APB_PSLVERR_EN.
package timer_apb_pkg;

    localparam int unsigned DW = 16;

    // Per-timer register offsets (paddr[3:2])
    localparam logic [1:0] OFS_CON = 2'd0;
    localparam logic [1:0] OFS_PRD = 2'd1;
    localparam logic [1:0] OFS_CNT = 2'd2;
    localparam logic [1:0] OFS_RSV = 2'd3;

    // Global bank select (paddr[7:4]) and its register offsets
    localparam logic [3:0] OFS_GLB  = 4'hF;
    localparam logic [1:0] GOFS_STAT = 2'd0;
    localparam logic [1:0] GOFS_EN   = 2'd1;
    localparam logic [1:0] GOFS_CLR  = 2'd2;
    localparam logic [1:0] GOFS_ID   = 2'd3;

    // Pending-clear bit in each timer's control word
    localparam int unsigned PND_CLR_BIT  = 10;
    localparam logic [DW-1:0] PND_CLR_MASK = DW'(1) << PND_CLR_BIT;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_CLR    = 2'd2,
        ST_DONE   = 2'd3
    } apb_state_e;

    // One-hot of the lowest set bit (zero in, zero out)
    function automatic logic [15:0] lowest_set(input logic [15:0] v);
        return v & (~v + 16'd1);
    endfunction

endpackage

// File: rtl/tmr_rr_arb.sv
// Round-robin interrupt arbiter.
// Ports: clk_i/rst_ni (sync active-low), req_i (masked pending lines),
// irq_o (registered OR of requests), grant_o (index of the held grant).
// A grant is held while its line stays high; when it drops the search
// pointer moves past it and a new search runs on the following cycle.
module tmr_rr_arb #(
    parameter int unsigned N = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    output logic         irq_o,
    output logic [3:0]   grant_o
);

    logic       vld_q, vld_d;
    logic [3:0] grant_q, grant_d;
    logic [3:0] ptr_q, ptr_d;
    logic       irq_q;

    logic       pick_vld_c;
    logic [3:0] pick_c;
    logic       held_c;
    logic [3:0] next_c;

    // Search from ptr upward first, then wrap to the low indices
    always_comb begin
        pick_vld_c = 1'b0;
        pick_c     = ptr_q;
        for (int j = 0; j < N; j++) begin
            if (!pick_vld_c && req_i[j] && (4'(j) >= ptr_q)) begin
                pick_vld_c = 1'b1;
                pick_c     = 4'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!pick_vld_c && req_i[j]) begin
                pick_vld_c = 1'b1;
                pick_c     = 4'(j);
            end
        end
    end

    // Is the granted line still requesting; where the pointer goes on release
    always_comb begin
        held_c = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (grant_q == 4'(j)) begin
                held_c = req_i[j];
            end
        end
        next_c = ((32'(grant_q) + 32'd1) >= N) ? 4'd0 : (grant_q + 4'd1);
    end

    always_comb begin
        vld_d   = vld_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (vld_q) begin
            if (!held_c) begin
                vld_d = 1'b0;
                ptr_d = next_c;
            end
        end else if (pick_vld_c) begin
            vld_d   = 1'b1;
            grant_d = pick_c;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q   <= 1'b0;
            grant_q <= 4'd0;
            ptr_q   <= 4'd0;
            irq_q   <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            irq_q   <= |req_i;
        end
    end

    assign irq_o   = irq_q;
    assign grant_o = grant_q;

endmodule

// File: rtl/timer_apb_ctrl.sv
// APB register front-end and interrupt scheduler for NTMR 16-bit timers.
// Ports: sys_clk/sys_rstn (sync active-low); APB slave psel/penable/pwrite/
// paddr/pwdata/prdata/pready; per-timer write strobes tmr_con_wr/tmr_prd_wr/
// tmr_cnt_wr with shared icb_wdat; timer readback tmr_con/tmr_prd/tmr_cnt;
// pending lines tmr_int; combined irq with granted index irq_id.
// Macro TMR_APB_PSLVERR_EN adds pslverr, flagged with pready on reserved
// offsets, absent timers and writes to read-only global registers.
module timer_apb_ctrl
    import timer_apb_pkg::*;
#(
    parameter int unsigned NTMR = 4,
    parameter int unsigned AW   = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rstn,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [AW-1:0]        paddr,
    input  logic [15:0]          pwdata,
    output logic [15:0]          prdata,
    output logic                 pready,
`ifdef TMR_APB_PSLVERR_EN
    output logic                 pslverr,
`endif
    output logic [NTMR-1:0]      tmr_con_wr,
    output logic [NTMR-1:0]      tmr_prd_wr,
    output logic [NTMR-1:0]      tmr_cnt_wr,
    output logic [15:0]          icb_wdat,
    input  logic [16*NTMR-1:0]   tmr_con,
    input  logic [16*NTMR-1:0]   tmr_prd,
    input  logic [16*NTMR-1:0]   tmr_cnt,
    input  logic [NTMR-1:0]      tmr_int,
    output logic                 irq,
    output logic [3:0]           irq_id
);

    apb_state_e      state_q, state_d;
    logic [NTMR-1:0] con_wr_q, con_wr_d;
    logic [NTMR-1:0] prd_wr_q, prd_wr_d;
    logic [NTMR-1:0] cnt_wr_q, cnt_wr_d;
    logic [15:0]     wdat_q, wdat_d;
    logic [15:0]     prdata_q, prdata_d;
    logic            pready_q;
    logic            err_q, err_d;
    logic            pslverr_q;
    logic [NTMR-1:0] irq_en_q, irq_en_d;
    logic [NTMR-1:0] clr_pend_q, clr_pend_d;

    logic [3:0]      bank_c;
    logic [1:0]      ofs_c;
    logic            is_glb_c;
    logic            tmr_ok_c;
    logic [NTMR-1:0] sel_c;
    logic [NTMR-1:0] irq_stat_c;
    logic [15:0]     con_rd_c, prd_rd_c, cnt_rd_c;
    logic [NTMR-1:0] clr_src_c, clr_oh_c, clr_rest_c;
    logic [15:0]     clr_oh16_c;
    logic [15:0]     clr_wdat_c;

    assign bank_c     = paddr[7:4];
    assign ofs_c      = paddr[3:2];
    assign is_glb_c   = (bank_c == OFS_GLB);
    assign tmr_ok_c   = |sel_c;
    assign irq_stat_c = tmr_int & irq_en_q;

    // The first clear is issued straight from pwdata in ACCESS, later ones from clr_pend
    assign clr_src_c  = (state_q == ST_ACCESS) ? pwdata[NTMR-1:0] : clr_pend_q;
    assign clr_oh16_c = lowest_set(16'(clr_src_c));
    assign clr_oh_c   = clr_oh16_c[NTMR-1:0];
    assign clr_rest_c = clr_src_c & ~clr_oh_c;

    // Bank decode and readback/clear-data muxes
    always_comb begin
        sel_c      = '0;
        con_rd_c   = '0;
        prd_rd_c   = '0;
        cnt_rd_c   = '0;
        clr_wdat_c = '0;
        for (int i = 0; i < NTMR; i++) begin
            if (bank_c == 4'(i)) begin
                sel_c[i] = 1'b1;
                con_rd_c = tmr_con[16*i +: 16];
                prd_rd_c = tmr_prd[16*i +: 16];
                cnt_rd_c = tmr_cnt[16*i +: 16];
            end
            if (clr_oh_c[i]) begin
                clr_wdat_c = tmr_con[16*i +: 16] | PND_CLR_MASK;
            end
        end
    end

    // Access FSM: next state and next register values
    always_comb begin
        state_d    = state_q;
        con_wr_d   = '0;
        prd_wr_d   = '0;
        cnt_wr_d   = '0;
        wdat_d     = wdat_q;
        prdata_d   = prdata_q;
        err_d      = err_q;
        irq_en_d   = irq_en_q;
        clr_pend_d = clr_pend_q;
        unique case (state_q)
            ST_IDLE: begin
                if (psel && !penable) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_DONE;
                err_d   = 1'b0;
                if (is_glb_c) begin
                    case (ofs_c)
                        GOFS_STAT: begin
                            if (pwrite) err_d = 1'b1;
                            else        prdata_d = 16'(irq_stat_c);
                        end
                        GOFS_EN: begin
                            if (pwrite) irq_en_d = pwdata[NTMR-1:0];
                            else        prdata_d = 16'(irq_en_q);
                        end
                        GOFS_CLR: begin
                            if (pwrite) begin
                                if (|clr_src_c) begin
                                    con_wr_d   = clr_oh_c;
                                    wdat_d     = clr_wdat_c;
                                    clr_pend_d = clr_rest_c;
                                    state_d    = (|clr_rest_c) ? ST_CLR : ST_DONE;
                                end
                            end else begin
                                prdata_d = '0;
                            end
                        end
                        default: begin
                            if (pwrite) err_d = 1'b1;
                            else        prdata_d = {irq, 11'd0, irq_id};
                        end
                    endcase
                end else if (tmr_ok_c) begin
                    case (ofs_c)
                        OFS_CON: begin
                            if (pwrite) begin
                                con_wr_d = sel_c;
                                wdat_d   = pwdata;
                            end else begin
                                prdata_d = con_rd_c;
                            end
                        end
                        OFS_PRD: begin
                            if (pwrite) begin
                                prd_wr_d = sel_c;
                                wdat_d   = pwdata;
                            end else begin
                                prdata_d = prd_rd_c;
                            end
                        end
                        OFS_CNT: begin
                            if (pwrite) begin
                                cnt_wr_d = sel_c;
                                wdat_d   = pwdata;
                            end else begin
                                prdata_d = cnt_rd_c;
                            end
                        end
                        default: begin
                            err_d = 1'b1;
                            if (!pwrite) prdata_d = '0;
                        end
                    endcase
                end else begin
                    err_d = 1'b1;
                    if (!pwrite) prdata_d = '0;
                end
            end
            ST_CLR: begin
                con_wr_d   = clr_oh_c;
                wdat_d     = clr_wdat_c;
                clr_pend_d = clr_rest_c;
                if (clr_rest_c == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            state_q    <= ST_IDLE;
            con_wr_q   <= '0;
            prd_wr_q   <= '0;
            cnt_wr_q   <= '0;
            wdat_q     <= '0;
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            err_q      <= 1'b0;
            pslverr_q  <= 1'b0;
            irq_en_q   <= '0;
            clr_pend_q <= '0;
        end else begin
            state_q    <= state_d;
            con_wr_q   <= con_wr_d;
            prd_wr_q   <= prd_wr_d;
            cnt_wr_q   <= cnt_wr_d;
            wdat_q     <= wdat_d;
            prdata_q   <= prdata_d;
            pready_q   <= (state_q == ST_DONE);
            err_q      <= err_d;
            pslverr_q  <= (state_q == ST_DONE) && err_q;
            irq_en_q   <= irq_en_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    tmr_rr_arb #(
        .N(NTMR)
    ) u_arb (
        .clk_i  (sys_clk),
        .rst_ni (sys_rstn),
        .req_i  (irq_stat_c),
        .irq_o  (irq),
        .grant_o(irq_id)
    );

    assign tmr_con_wr = con_wr_q;
    assign tmr_prd_wr = prd_wr_q;
    assign tmr_cnt_wr = cnt_wr_q;
    assign icb_wdat   = wdat_q;
    assign prdata     = prdata_q;
    assign pready     = pready_q;

`ifdef TMR_APB_PSLVERR_EN
    assign pslverr = pslverr_q;
`else
    logic unused_err;
    assign unused_err = pslverr_q;
`endif

    logic unused_bits;
    assign unused_bits = ^{paddr[1:0], clr_oh16_c[15:NTMR]};

endmodule

// File: tb/tb_timer_apb_ctrl.sv
// Directed bench for timer_apb_ctrl (NTMR=4). Inputs are driven and outputs
// sampled on the falling edge; cycle c0 is the APB setup cycle.
module tb_timer_apb_ctrl;

    localparam int unsigned NTMR = 4;

    logic             sys_clk = 1'b0;
    logic             sys_rstn;
    logic             psel, penable, pwrite;
    logic [7:0]       paddr;
    logic [15:0]      pwdata;
    logic [15:0]      prdata;
    logic             pready;
    logic [NTMR-1:0]  tmr_con_wr, tmr_prd_wr, tmr_cnt_wr;
    logic [15:0]      icb_wdat;
    logic [16*NTMR-1:0] tmr_con, tmr_prd, tmr_cnt;
    logic [NTMR-1:0]  tmr_int;
    logic             irq;
    logic [3:0]       irq_id;
`ifdef TMR_APB_PSLVERR_EN
    logic             pslverr;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 sys_clk = ~sys_clk;

    timer_apb_ctrl #(
        .NTMR(NTMR),
        .AW  (8)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rstn  (sys_rstn),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
`ifdef TMR_APB_PSLVERR_EN
        .pslverr   (pslverr),
`endif
        .tmr_con_wr(tmr_con_wr),
        .tmr_prd_wr(tmr_prd_wr),
        .tmr_cnt_wr(tmr_cnt_wr),
        .icb_wdat  (icb_wdat),
        .tmr_con   (tmr_con),
        .tmr_prd   (tmr_prd),
        .tmr_cnt   (tmr_cnt),
        .tmr_int   (tmr_int),
        .irq       (irq),
        .irq_id    (irq_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive setup at c0, return at c1 with penable raised
    task automatic apb_begin(input logic wr, input logic [7:0] a, input logic [15:0] d);
        @(negedge sys_clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge sys_clk);
        penable = 1'b1;
    endtask

    task automatic apb_end();
        psel = 1'b0; penable = 1'b0;
    endtask

    function automatic logic [31:0] strobes();
        return 32'({tmr_cnt_wr, tmr_prd_wr, tmr_con_wr});
    endfunction

    initial begin
        sys_rstn = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        tmr_con = {16'h0012, 16'h0777, 16'h0888, 16'h0035};
        tmr_prd = {16'h4444, 16'h5555, 16'h6666, 16'h7777};
        tmr_cnt = {16'h3333, 16'h2222, 16'hBEEF, 16'h1111};
        tmr_int = '0;
        repeat (3) @(negedge sys_clk);

        // Reset values
        chk("rst_strobes", strobes(), 32'h0);
        chk("rst_wdat",    32'(icb_wdat), 32'h0);
        chk("rst_prdata",  32'(prdata), 32'h0);
        chk("rst_pready",  32'(pready), 32'h0);
        chk("rst_irq",     32'(irq), 32'h0);
        chk("rst_irq_id",  32'(irq_id), 32'h0);
        sys_rstn = 1'b1;

        // Write timer 2 PRD = 0x1234
        apb_begin(1'b1, 8'h24, 16'h1234);
        chk("wr_c1_strobes", strobes(), 32'h0);
        chk("wr_c1_pready",  32'(pready), 32'h0);
        @(negedge sys_clk);
        chk("wr_c2_strobes", strobes(), 32'h040);
        chk("wr_c2_wdat",    32'(icb_wdat), 32'h1234);
        chk("wr_c2_pready",  32'(pready), 32'h0);
        @(negedge sys_clk);
        chk("wr_c3_pready",  32'(pready), 32'h1);
        chk("wr_c3_strobes", strobes(), 32'h0);
`ifdef TMR_APB_PSLVERR_EN
        chk("wr_c3_pslverr", 32'(pslverr), 32'h0);
`endif
        apb_end();
        @(negedge sys_clk);
        chk("wr_c4_pready",  32'(pready), 32'h0);

        // Read timer 1 CNT, then absent timer 7
        apb_begin(1'b0, 8'h18, 16'h0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("rd_cnt1_pready", 32'(pready), 32'h1);
        chk("rd_cnt1_data",   32'(prdata), 32'hBEEF);
        apb_end();
        apb_begin(1'b0, 8'h70, 16'h0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("rd_t7_pready", 32'(pready), 32'h1);
        chk("rd_t7_data",   32'(prdata), 32'h0);
        apb_end();

        // IRQ_EN write and readback
        apb_begin(1'b1, 8'hF4, 16'h000F);
        @(negedge sys_clk);
        @(negedge sys_clk);
        apb_end();
        apb_begin(1'b0, 8'hF4, 16'h0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("rd_irq_en", 32'(prdata), 32'h000F);
        apb_end();

        // Pending clear of timers 0 and 3
        apb_begin(1'b1, 8'hF8, 16'h0009);
        @(negedge sys_clk);
        chk("clr_a_strobes", strobes(), 32'h001);
        chk("clr_a_wdat",    32'(icb_wdat), 32'h0435);
        chk("clr_a_pready",  32'(pready), 32'h0);
        @(negedge sys_clk);
        chk("clr_b_strobes", strobes(), 32'h008);
        chk("clr_b_wdat",    32'(icb_wdat), 32'h0412);
        chk("clr_b_pready",  32'(pready), 32'h0);
        @(negedge sys_clk);
        chk("clr_done_pready",  32'(pready), 32'h1);
        chk("clr_done_strobes", strobes(), 32'h0);
        apb_end();

        // Round-robin scheduling
        @(negedge sys_clk);
        tmr_int = 4'b1010;
        @(negedge sys_clk);
        chk("rr_irq_on", 32'(irq), 32'h1);
        chk("rr_id1",    32'(irq_id), 32'h1);
        @(negedge sys_clk);
        chk("rr_id1_hold", 32'(irq_id), 32'h1);
        tmr_int = 4'b1000;
        @(negedge sys_clk);
        chk("rr_release_id", 32'(irq_id), 32'h1);
        chk("rr_release_irq", 32'(irq), 32'h1);
        @(negedge sys_clk);
        chk("rr_id3", 32'(irq_id), 32'h3);
        tmr_int = 4'b0000;
        @(negedge sys_clk);
        chk("rr_irq_off",  32'(irq), 32'h0);
        chk("rr_id3_keep", 32'(irq_id), 32'h3);
        tmr_int = 4'b0001;
        @(negedge sys_clk);
        chk("rr_wrap_id0", 32'(irq_id), 32'h0);
        tmr_int = 4'b0101;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("rr_no_preempt", 32'(irq_id), 32'h0);

        // Masking the held grant via IRQ_EN releases it
        apb_begin(1'b1, 8'hF4, 16'h000E);
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("mask_c3_id", 32'(irq_id), 32'h0);
        apb_end();
        @(negedge sys_clk);
        chk("mask_c4_id",  32'(irq_id), 32'h2);
        chk("mask_c4_irq", 32'(irq), 32'h1);

        // Global read-only registers
        apb_begin(1'b0, 8'hFC, 16'h0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("rd_irq_id_reg", 32'(prdata), 32'h8002);
        apb_end();
        apb_begin(1'b0, 8'hF0, 16'h0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("rd_irq_stat", 32'(prdata), 32'h0004);
        apb_end();

        // Reset during a four-timer clear, after the first strobe
        apb_begin(1'b1, 8'hF8, 16'h000F);
        @(negedge sys_clk);
        chk("rclr_first", strobes(), 32'h001);
        chk("rclr_wdat",  32'(icb_wdat), 32'h0435);
        sys_rstn = 1'b0;
        apb_end();
        @(negedge sys_clk);
        chk("rclr_strobes", strobes(), 32'h0);
        chk("rclr_wdat0",   32'(icb_wdat), 32'h0);
        chk("rclr_prdata",  32'(prdata), 32'h0);
        chk("rclr_pready",  32'(pready), 32'h0);
        chk("rclr_irq",     32'(irq), 32'h0);
        chk("rclr_irq_id",  32'(irq_id), 32'h0);
        sys_rstn = 1'b1;
        @(negedge sys_clk);
        chk("rclr_quiet1", strobes(), 32'h0);
        @(negedge sys_clk);
        chk("rclr_quiet2", strobes(), 32'h0);
        chk("rclr_irq_masked", 32'(irq), 32'h0);

        // psel dropped after setup: transfer still completes
        @(negedge sys_clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 16'hA5A5;
        @(negedge sys_clk);
        psel = 1'b0;
        @(negedge sys_clk);
        chk("drop_strobes", strobes(), 32'h100);
        chk("drop_wdat",    32'(icb_wdat), 32'hA5A5);
        @(negedge sys_clk);
        chk("drop_pready",  32'(pready), 32'h1);

        // Reserved offset write: no strobe
        apb_begin(1'b1, 8'h0C, 16'hFFFF);
        @(negedge sys_clk);
        chk("rsv_strobes", strobes(), 32'h0);
        @(negedge sys_clk);
        chk("rsv_pready", 32'(pready), 32'h1);
`ifdef TMR_APB_PSLVERR_EN
        chk("rsv_pslverr", 32'(pslverr), 32'h1);
`endif
        apb_end();

        // Write to absent timer 7: no strobe
        apb_begin(1'b1, 8'h70, 16'h5A5A);
        @(negedge sys_clk);
        chk("t7_strobes", strobes(), 32'h0);
        @(negedge sys_clk);
        chk("t7_pready", 32'(pready), 32'h1);
`ifdef TMR_APB_PSLVERR_EN
        chk("t7_pslverr", 32'(pslverr), 32'h1);
`endif
        apb_end();
        @(negedge sys_clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
